// File: rtl/chroma_quad_modulator.sv
// ---------------------------------------------------------------------------
// ChromaQuadModulator (module chroma_quad_modulator)
//
// Quadrature chroma modulator for composite video. A small line-timing FSM,
// restarted by every rising edge of hsync, decides per clock whether the
// modulator carries the colour burst, pixel colour-difference data, or
// nothing. A three-stage pipeline then forms U*sin + V*cos, rescales it
// back to sample width and flags what kind of sample came out.
//
// Optional build macro:
//   CHROMA_SAT_EN  - when defined, the rescaled result saturates to the
//                    signed DATA_WIDTH range; otherwise it wraps.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sin_val      in   NCO sine sample   (signed DATA_WIDTH)
//   cos_val      in   NCO cosine sample (signed DATA_WIDTH)
//   u_in         in   pixel U colour-difference (signed DATA_WIDTH)
//   v_in         in   pixel V colour-difference (signed DATA_WIDTH)
//   in_valid     in   u_in/v_in valid this cycle
//   hsync        in   line-start marker, rising edge detected internally
//   active       in   active-video window flag
//   chroma_out   out  modulated chroma sample (signed DATA_WIDTH)
//   chroma_valid out  chroma_out carries pixel data
//   burst_active out  chroma_out carries colour burst
// ---------------------------------------------------------------------------
module chroma_quad_modulator #(
    parameter int DATA_WIDTH  = 12,
    parameter int BURST_START = 16,
    parameter int BURST_LEN   = 36,
    parameter int BURST_AMP   = 512
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] sin_val,
    input  logic signed [DATA_WIDTH-1:0] cos_val,
    input  logic signed [DATA_WIDTH-1:0] u_in,
    input  logic signed [DATA_WIDTH-1:0] v_in,
    input  logic                         in_valid,
    input  logic                         hsync,
    input  logic                         active,
    output logic signed [DATA_WIDTH-1:0] chroma_out,
    output logic                         chroma_valid,
    output logic                         burst_active
);

    localparam int PW = 2 * DATA_WIDTH;

    localparam logic [15:0] START_LAST = 16'(BURST_START - 1);
    localparam logic [15:0] LEN_LAST   = 16'(BURST_LEN - 1);

    // Burst sits on the negative U axis.
    localparam logic signed [DATA_WIDTH-1:0] BURST_U = DATA_WIDTH'(-BURST_AMP);

`ifdef CHROMA_SAT_EN
    localparam logic signed [PW:0] SAT_MAX = (PW + 1)'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [PW:0] SAT_MIN = (PW + 1)'(-(2 ** (DATA_WIDTH - 1)));
    localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = DATA_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = DATA_WIDTH'(-(2 ** (DATA_WIDTH - 1)));
`endif

    typedef enum logic [2:0] {
        IDLE,
        BLANK_WAIT,
        BURST,
        POST,
        ACTIVE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        hsync_q;
    logic        hsyncRise;

    logic signed [DATA_WIDTH-1:0] u1_q, v1_q, sin1_q, cos1_q;
    logic signed [DATA_WIDTH-1:0] u1_d, v1_d;
    logic                         valid1_q, burst1_q, valid1_d, burst1_d;

    logic signed [PW-1:0] prodU2_q, prodV2_q, prodU2_d, prodV2_d;
    logic signed [PW-1:0] uExt, vExt, sinExt, cosExt;
    logic                 valid2_q, burst2_q;

    logic signed [PW:0]           sumA, sumB, sumW, shifted;
    logic signed [DATA_WIDTH-1:0] chroma3_q, chroma3_d;
    logic                         valid3_q, burst3_q;

    assign hsyncRise = hsync && !hsync_q;

    // Line-timing state, cycle counter and the hsync history bit used for
    // edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hsync_q <= hsync;
        end
    end

    // Next-state logic. A fresh hsync edge restarts the line from any state
    // and overrides every other transition. The counter is reused in
    // BLANK_WAIT and BURST and cleared on each of those entries.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (hsyncRise) begin
            state_d = BLANK_WAIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: ;
                BLANK_WAIT: begin
                    if (cnt_q == START_LAST) begin
                        state_d = BURST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                BURST: begin
                    if (cnt_q == LEN_LAST) begin
                        state_d = POST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                POST: begin
                    if (active) state_d = ACTIVE;
                end
                ACTIVE: begin
                    if (!active) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Stage-1 operand selection from the current line state: burst vector,
    // live pixel data, or zero.
    always_comb begin
        u1_d     = '0;
        v1_d     = '0;
        valid1_d = 1'b0;
        burst1_d = 1'b0;
        if (state_q == BURST) begin
            u1_d     = BURST_U;
            burst1_d = 1'b1;
        end else if (state_q == ACTIVE && in_valid) begin
            u1_d     = u_in;
            v1_d     = v_in;
            valid1_d = 1'b1;
        end
    end

    // Stage 1: operands and carrier samples captured together so they stay
    // phase-aligned through the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u1_q     <= '0;
            v1_q     <= '0;
            sin1_q   <= '0;
            cos1_q   <= '0;
            valid1_q <= 1'b0;
            burst1_q <= 1'b0;
        end else begin
            u1_q     <= u1_d;
            v1_q     <= v1_d;
            sin1_q   <= sin_val;
            cos1_q   <= cos_val;
            valid1_q <= valid1_d;
            burst1_q <= burst1_d;
        end
    end

    // Full-precision signed products; operands are sign-extended first so
    // the multiply is done at product width.
    always_comb begin
        uExt     = {{DATA_WIDTH{u1_q[DATA_WIDTH-1]}}, u1_q};
        vExt     = {{DATA_WIDTH{v1_q[DATA_WIDTH-1]}}, v1_q};
        sinExt   = {{DATA_WIDTH{sin1_q[DATA_WIDTH-1]}}, sin1_q};
        cosExt   = {{DATA_WIDTH{cos1_q[DATA_WIDTH-1]}}, cos1_q};
        prodU2_d = uExt * sinExt;
        prodV2_d = vExt * cosExt;
    end

    // Stage 2: product registers and their sample-type flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prodU2_q <= '0;
            prodV2_q <= '0;
            valid2_q <= 1'b0;
            burst2_q <= 1'b0;
        end else begin
            prodU2_q <= prodU2_d;
            prodV2_q <= prodV2_d;
            valid2_q <= valid1_q;
            burst2_q <= burst1_q;
        end
    end

    // The sum gets one guard bit so two full-scale products cannot overflow.
    // The arithmetic shift floors toward minus infinity, then the result is
    // either clamped or wrapped back to sample width.
    always_comb begin
        sumA    = {prodU2_q[PW-1], prodU2_q};
        sumB    = {prodV2_q[PW-1], prodV2_q};
        sumW    = sumA + sumB;
        shifted = sumW >>> (DATA_WIDTH - 1);
`ifdef CHROMA_SAT_EN
        if (shifted > SAT_MAX) begin
            chroma3_d = OUT_MAX;
        end else if (shifted < SAT_MIN) begin
            chroma3_d = OUT_MIN;
        end else begin
            chroma3_d = shifted[DATA_WIDTH-1:0];
        end
`else
        chroma3_d = DATA_WIDTH'(shifted);
`endif
    end

    // Stage 3: output register. Idle samples naturally come out as zero with
    // both flags low because their operands were zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chroma3_q <= '0;
            valid3_q  <= 1'b0;
            burst3_q  <= 1'b0;
        end else begin
            chroma3_q <= chroma3_d;
            valid3_q  <= valid2_q;
            burst3_q  <= burst2_q;
        end
    end

    assign chroma_out   = chroma3_q;
    assign chroma_valid = valid3_q;
    assign burst_active = burst3_q;

endmodule

// File: tb/tb_chroma_quad_modulator.sv
// ---------------------------------------------------------------------------
// TbChromaQuadModulator (module tb_chroma_quad_modulator)
//
// Directed bench for chroma_quad_modulator with default parameters.
// Expected values are hand-computed constants. Saturation-dependent
// expectations follow the CHROMA_SAT_EN macro.
// ---------------------------------------------------------------------------
module tb_chroma_quad_modulator;

    logic               clk;
    logic               rst_n;
    logic signed [11:0] sinVal, cosVal, uIn, vIn;
    logic               inValid, hsync, active;
    logic signed [11:0] chromaOut;
    logic               chromaValid, burstActive;

    int total = 0;
    int bad   = 0;

`ifdef CHROMA_SAT_EN
    localparam int EXP_BIG_POS = 2047;
    localparam int EXP_OVER    = 2047;
    localparam int EXP_NEG     = -2048;
`else
    localparam int EXP_BIG_POS = -4;
    localparam int EXP_OVER    = 0;
    localparam int EXP_NEG     = 2;
`endif

    localparam int NV = 9;
    int vecU[NV]   = '{0,    2047, -1000, 300,  -2048, -2048, -2048, 1, -1};
    int vecV[NV]   = '{1024, 2047, 500,   -200, -2048, 0,     -2048, 0, 0};
    int vecS[NV]   = '{0,    2047, 1500,  -2048, -2048, 2047, 2047,  1, 1};
    int vecC[NV]   = '{2047, 2047, -800,  1000, -2048, 0,     2047,  0, 0};
    int vecExp[NV] = '{1023, EXP_BIG_POS, -928, -398, EXP_OVER, -2047, EXP_NEG, 0, -1};

    chroma_quad_modulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sin_val      (sinVal),
        .cos_val      (cosVal),
        .u_in         (uIn),
        .v_in         (vIn),
        .in_valid     (inValid),
        .hsync        (hsync),
        .active       (active),
        .chroma_out   (chromaOut),
        .chroma_valid (chromaValid),
        .burst_active (burstActive)
    );

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    // Drives the data-path inputs in one go.
    task automatic applyStimulus(input logic iv, input int u, input int v, input int s, input int c);
        inValid = iv;
        uIn     = 12'(u);
        vIn     = 12'(v);
        sinVal  = 12'(s);
        cosVal  = 12'(c);
    endtask

    // Advances one clock and settles just past the rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Emits an hsync pulse one clock wide.
    task automatic pulseHsync();
        hsync = 1'b1;
        nextCycle();
        hsync = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        hsync  = 1'b0;
        active = 1'b0;
        applyStimulus(1'b0, 0, 0, 0, 0);

        // Reset state.
        nextCycle();
        nextCycle();
        checkOutput("rst_chroma", chromaOut, 0);
        checkOutput("rst_valid", chromaValid, 0);
        checkOutput("rst_burst", burstActive, 0);

        rst_n = 1'b1;
        nextCycle();

        // Idle FSM ignores active/in_valid until a line starts.
        active = 1'b1;
        applyStimulus(1'b1, 700, 700, 2047, 2047);
        for (int k = 1; k <= 4; k++) begin
            nextCycle();
            checkOutput("idle_valid", chromaValid, 0);
            checkOutput("idle_chroma", chromaOut, 0);
        end
        active = 1'b0;

        // Burst timing and amplitude from a single line start.
        applyStimulus(1'b0, 0, 0, 2047, 0);
        pulseHsync();
        for (int k = 1; k <= 60; k++) begin
            automatic logic expB = (k >= 19) && (k <= 54);
            nextCycle();
            checkOutput($sformatf("burst_flag_k%0d", k), burstActive, int'(expB));
            checkOutput($sformatf("burst_val_k%0d", k), chromaOut, expB ? -512 : 0);
            checkOutput($sformatf("burst_valid_k%0d", k), chromaValid, 0);
        end

        // POST -> ACTIVE.
        active = 1'b1;
        nextCycle();

        // ACTIVE with in_valid low produces nothing.
        applyStimulus(1'b0, 500, 500, 2047, 2047);
        for (int k = 1; k <= 4; k++) begin
            nextCycle();
            checkOutput("noval_chroma", chromaOut, 0);
            checkOutput("noval_valid", chromaValid, 0);
            checkOutput("noval_burst", burstActive, 0);
        end

        // Single valid sample: exactly three cycles of latency.
        applyStimulus(1'b1, 0, 1024, 0, 2047);
        nextCycle();
        applyStimulus(1'b0, 0, 0, 0, 2047);
        checkOutput("lat_valid_c1", chromaValid, 0);
        nextCycle();
        checkOutput("lat_valid_c2", chromaValid, 0);
        nextCycle();
        checkOutput("lat_valid_c3", chromaValid, 1);
        checkOutput("lat_chroma_c3", chromaOut, 1023);
        nextCycle();
        checkOutput("lat_valid_c4", chromaValid, 0);

        // Back-to-back vectors streaming through the pipeline.
        for (int s = 0; s < NV + 2; s++) begin
            if (s < NV) applyStimulus(1'b1, vecU[s], vecV[s], vecS[s], vecC[s]);
            else        applyStimulus(1'b0, 0, 0, 0, 0);
            nextCycle();
            if (s >= 2) begin
                checkOutput($sformatf("vec%0d_valid", s - 2), chromaValid, 1);
                checkOutput($sformatf("vec%0d_chroma", s - 2), chromaOut, vecExp[s - 2]);
            end
        end
        nextCycle();
        checkOutput("vec_tail_valid", chromaValid, 0);

        // ACTIVE -> IDLE, then restart in the middle of a burst.
        active = 1'b0;
        applyStimulus(1'b0, 0, 0, 2047, 0);
        nextCycle();
        pulseHsync();
        for (int k = 1; k <= 24; k++) nextCycle();
        checkOutput("restart_pre_burst", burstActive, 1);
        pulseHsync();
        for (int k = 1; k <= 60; k++) begin
            automatic logic expB = (k <= 2) || ((k >= 19) && (k <= 54));
            nextCycle();
            checkOutput($sformatf("restart_flag_k%0d", k), burstActive, int'(expB));
            checkOutput($sformatf("restart_val_k%0d", k), chromaOut, expB ? -512 : 0);
        end

        // Asynchronous reset in the middle of active video.
        active = 1'b1;
        nextCycle();
        applyStimulus(1'b1, 0, 1024, 0, 2047);
        for (int k = 1; k <= 4; k++) nextCycle();
        checkOutput("pre_rst_valid", chromaValid, 1);
        checkOutput("pre_rst_chroma", chromaOut, 1023);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_chroma", chromaOut, 0);
        checkOutput("async_rst_valid", chromaValid, 0);
        checkOutput("async_rst_burst", burstActive, 0);
        nextCycle();
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            nextCycle();
            checkOutput($sformatf("post_rst_valid_k%0d", k), chromaValid, 0);
            checkOutput($sformatf("post_rst_chroma_k%0d", k), chromaOut, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chroma_quad_modulator.md
CHROMA_QUAD_MODULATOR -- requirements
Module: chroma_quad_modulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, sample width of sin/cos, U/V and chroma.
REQ-002 SHALL have parameter BURST_START, default 16, clk cycles from hsync rise to burst start.
REQ-003 SHALL have parameter BURST_LEN, default 36, burst duration in clk cycles.
REQ-004 SHALL have parameter BURST_AMP, default 512, burst U-axis magnitude (positive, < 2^(DATA_WIDTH-1)).
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port sin_val  input  DATA_WIDTH signed  NCO sine sample.
REQ-008 SHALL have port cos_val  input  DATA_WIDTH signed  NCO cosine sample.
REQ-009 SHALL have port u_in  input  DATA_WIDTH signed  pixel U colour-difference.
REQ-010 SHALL have port v_in  input  DATA_WIDTH signed  pixel V colour-difference.
REQ-011 SHALL have port in_valid  input  1  u_in/v_in valid this cycle.
REQ-012 SHALL have port hsync  input  1  line-start marker, active high, edge-detected internally.
REQ-013 SHALL have port active  input  1  active-video window flag.
REQ-014 SHALL have port chroma_out  output  DATA_WIDTH signed  modulated chroma sample.
REQ-015 SHALL have port chroma_valid  output  1  chroma_out carries pixel data.
REQ-016 SHALL have port burst_active  output  1  chroma_out carries colour burst.

Function
REQ-017 SHALL implement FSM IDLE, BLANK_WAIT, BURST, POST, ACTIVE, with a 16-bit cycle counter.
REQ-018 SHALL go IDLE->BLANK_WAIT on hsync rising edge (hsync high, registered hsync low), counter cleared.
REQ-019 SHALL go BLANK_WAIT->BURST when counter reaches BURST_START-1; BURST->POST after BURST_LEN cycles in BURST.
REQ-020 SHALL go POST->ACTIVE when active=1; ACTIVE->IDLE when active=0.
REQ-021 SHALL, on hsync rising edge in any state, enter BLANK_WAIT with counter cleared (restart wins over all other transitions).
REQ-022 SHALL, stage 1, register operands: BURST -> (U=-BURST_AMP, V=0); ACTIVE with in_valid -> (u_in, v_in); otherwise (0, 0); sin_val/cos_val registered same cycle.
REQ-023 SHALL, stage 2, register signed 2*DATA_WIDTH products U*sin and V*cos.
REQ-024 SHALL, stage 3, register chroma = (U*sin + V*cos) arithmetic-shifted right by DATA_WIDTH-1 (floor), reduced to DATA_WIDTH per REQ-031.
REQ-025 SHALL have fixed latency 3 cycles from operand sampling to chroma_out.
REQ-026 SHALL assert chroma_valid 3 cycles after a stage-1 ACTIVE+in_valid cycle, burst_active 3 cycles after a stage-1 BURST cycle; never both.
REQ-027 SHALL drive chroma_out=0 with both flags low when stage-1 operands were (0, 0) from idle selection.
REQ-028 SHALL let pipeline drain normally on FSM restart; in-flight samples are not cancelled.

Reset
REQ-029 SHALL, while rst_n=0, force FSM to IDLE, counter, hsync register and all pipeline registers to 0.
REQ-030 SHALL, during reset, hold chroma_out=0, chroma_valid=0, burst_active=0; first valid output no earlier than 3 cycles after a post-reset ACTIVE+in_valid cycle.

Configuration
REQ-031 SHALL, with CHROMA_SAT_EN defined, saturate stage-3 result to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; without it, truncate to low DATA_WIDTH bits (two's-complement wrap).

Verification
REQ-032 SHALL test: ACTIVE, in_valid=1, u=0, v=1024, sin=0, cos=2047 -> chroma_out=1023, chroma_valid=1 exactly 3 cycles later.
REQ-033 SHALL test: u=v=sin=cos=2047 -> chroma_out=2047 with CHROMA_SAT_EN, -4 without.
REQ-034 SHALL test: hsync rise, defaults, sin held 2047 -> burst_active high for 36 cycles starting 16+3 cycles after edge, chroma_out=-512.
REQ-035 SHALL test: second hsync rise mid-BURST -> burst restarts, BLANK_WAIT for 16 cycles, full 36-cycle burst follows.
REQ-036 SHALL test: rst_n low mid-ACTIVE -> outputs 0 immediately (async); after release FSM idle until next hsync rise.
REQ-037 SHALL test: ACTIVE with in_valid=0 -> chroma_out=0, chroma_valid=0.
